if_stage_fetch_unit: RTL and testbench
======================================

Name: if_stage_fetch_unit

Overview:
- Instruction-fetch stage plus IF/ID pipeline register. It sits directly upstream of the ID stage whose hazard detector generates `freeze`.
- Holds the PC and issues requests to the instruction-memory controller over a req/ready handshake.
- Buffers one returned instruction while the pipeline is frozen.
- Flushes and redirects on a taken branch from EXE.
- Keeps a retired-fetch counter for performance monitoring.

Parameters:
- ADDR_W, 32, PC / instruction-address width
- DATA_W, 32, instruction width
- RESET_PC, 0, PC value loaded at reset
- PC_STEP, 4, PC increment per accepted instruction
- CNT_W, 32, width of fetch counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous reset, active-low
- freeze  in  1  stall from hazard detection; holds IF/ID and PC
- branch_taken  in  1  taken branch resolved in EXE
- branch_addr  in  ADDR_W  branch target
- imem_req  out  1  fetch request, Moore output of FSM
- imem_addr  out  ADDR_W  fetch address (= PC)
- imem_rdata  in  DATA_W  returned instruction, valid when imem_ready
- imem_ready  in  1  memory has completed the request this cycle
- if_id_pc  out  ADDR_W  PC+PC_STEP of the instruction in IF/ID
- if_id_instr  out  DATA_W  instruction in IF/ID
- if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble)
- fetch_count  out  CNT_W  number of instructions written into IF/ID

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, state=REDIR.
  - if_id_pc=0, if_id_instr=0, if_id_valid=0, fetch_count=0.
  - Skid buffer is invalid, imem_req=0.
  - Reset asserted in any state aborts the operation immediately, with no further memory requests.
- FSM states:
  - REDIR: imem_req=0 for exactly one cycle so the memory controller terminates any open access. Transitions unconditionally to REQ. IF/ID valid<=0 (unless freeze, then IF/ID holds).
  - REQ: imem_req=1, imem_addr=pc, and imem_addr is stable while waiting.
    - imem_ready=1, freeze=0: IF/ID <= {pc+PC_STEP, imem_rdata, valid=1}; pc <= pc+PC_STEP; fetch_count++; stay in REQ.
    - imem_ready=1, freeze=1: buffer <= {pc+PC_STEP, imem_rdata}; pc <= pc+PC_STEP; IF/ID holds; go to HOLD.
    - imem_ready=0: pc holds. IF/ID valid<=0 if freeze=0 (bubble); IF/ID holds if freeze=1.
  - HOLD: imem_req=0 and IF/ID holds while freeze=1. On freeze=0: IF/ID <= buffer with valid=1; fetch_count++; go to REQ.
- Branch (highest priority, evaluated in every state):
  - pc <= branch_addr; IF/ID valid<=0 and instr<=0, even if freeze=1.
  - Buffer is discarded, any imem_rdata returning this cycle is discarded, and fetch_count is not incremented.
  - Next state is REDIR.
- Arithmetic:
  - pc+PC_STEP wraps modulo 2^ADDR_W with no overflow flag.
  - fetch_count wraps to 0 after all-ones.
- Latency: instruction available at the edge of ready → visible at the IF/ID outputs after that same edge (one register stage). The minimum distance from reset release to the first valid IF/ID is 2 rising edges.
- Width rule: imem_addr is driven directly from pc with no truncation.

Test Plan:
- Reset release, imem_ready=1 every cycle, imem_rdata=addr|0xA000_0000:
  - Edge 1: imem_req rises.
  - Edge 2: if_id_pc=0x4, instr=0xA000_0000, valid=1.
  - Subsequent edges: pc 0x8, 0xC.
  - fetch_count increments 1, 2, 3.
- Steady fetch at pc=0x10, freeze=1 for 2 cycles with ready=1:
  - IF/ID holds its previous entry.
  - Instruction at 0x10 is buffered; imem_req=0 in HOLD.
  - On the edge after freeze drops, if_id_pc=0x14 with valid=1.
  - Next request addr=0x14; fetch_count increments by exactly 1.
- branch_taken with branch_addr=0x40 while in REQ with ready=1:
  - Next edge: valid=0, returned data dropped, count unchanged.
  - imem_req=0 for one cycle.
  - Next request has imem_addr=0x40; the first valid if_id_pc is 0x44.
- branch_taken and freeze both high while in HOLD: buffer discarded, IF/ID valid=0, REDIR, then request at branch_addr.
- imem_ready=0 for 3 cycles at pc=0x8, freeze=0: imem_addr stays 0x8, three bubbles (valid=0), pc stays 0x8, then a normal fetch.
- rst pulsed low mid-HOLD:
  - All outputs immediately 0 and imem_req=0.
  - After release, fetch restarts at RESET_PC.
  - The buffered instruction never appears.

Source files
------------

// File: rtl/if_stage_fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register, one-entry skid buffer
// for freeze, branch redirect and a retired-fetch counter.
module if_stage_fetch_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned PC_STEP = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [DATA_W-1:0] if_id_instr,
    output logic              if_id_valid,
    output logic [CNT_W-1:0]  fetch_count
);

    typedef enum logic [1:0] {
        S_REDIR = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] buf_pc;
    logic [DATA_W-1:0] buf_instr;
    logic              buf_valid;

    assign pc_inc    = pc + ADDR_W'(PC_STEP);
    assign imem_addr = pc;

    // imem_req is registered alongside the state so it is a clean Moore output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_REDIR;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= '0;
            if_id_valid <= 1'b0;
            fetch_count <= '0;
            buf_pc      <= '0;
            buf_instr   <= '0;
            buf_valid   <= 1'b0;
        end else if (branch_taken) begin
            // Redirect wins over freeze and any data returning this cycle
            pc          <= branch_addr;
            if_id_valid <= 1'b0;
            if_id_instr <= '0;
            buf_valid   <= 1'b0;
            state       <= S_REDIR;
            imem_req    <= 1'b0;
        end else begin
            case (state)
                S_REDIR: begin
                    if (!freeze) begin
                        if_id_valid <= 1'b0;
                    end
                    state    <= S_REQ;
                    imem_req <= 1'b1;
                end
                S_REQ: begin
                    if (imem_ready) begin
                        pc <= pc_inc;
                        if (freeze) begin
                            buf_pc    <= pc_inc;
                            buf_instr <= imem_rdata;
                            buf_valid <= 1'b1;
                            state     <= S_HOLD;
                            imem_req  <= 1'b0;
                        end else begin
                            if_id_pc    <= pc_inc;
                            if_id_instr <= imem_rdata;
                            if_id_valid <= 1'b1;
                            fetch_count <= fetch_count + CNT_W'(1);
                        end
                    end else if (!freeze) begin
                        if_id_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!freeze) begin
                        if_id_pc    <= buf_pc;
                        if_id_instr <= buf_instr;
                        if_id_valid <= buf_valid;
                        if (buf_valid) begin
                            fetch_count <= fetch_count + CNT_W'(1);
                        end
                        buf_valid <= 1'b0;
                        state     <= S_REQ;
                        imem_req  <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_REDIR;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage_fetch_unit.sv
// Directed bench for if_stage_fetch_unit; memory returns addr | 0xA000_0000.
module tb_if_stage_fetch_unit;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    int unsigned tests;
    int unsigned fails;

    if_stage_fetch_unit #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .RESET_PC(32'h0),
        .PC_STEP (4),
        .CNT_W   (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .branch_taken(branch_taken),
        .branch_addr (branch_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid),
        .fetch_count (fetch_count)
    );

    assign imem_rdata = imem_addr | 32'hA000_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic valid, input logic [31:0] cnt);
        chk({tag, ".pc"}, 64'(if_id_pc), 64'(pc));
        chk({tag, ".instr"}, 64'(if_id_instr), 64'(instr));
        chk({tag, ".valid"}, 64'(if_id_valid), 64'(valid));
        chk({tag, ".count"}, 64'(fetch_count), 64'(cnt));
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, ".req"}, 64'(imem_req), 64'(req));
        chk({tag, ".addr"}, 64'(imem_addr), 64'(addr));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        freeze = 1'b0;
        branch_taken = 1'b0;
        branch_addr = '0;
        imem_ready = 1'b1;

        #12;
        chk_req("reset", 1'b0, 32'h0);
        chk_ifid("reset", 32'h0, 32'h0, 1'b0, 32'd0);
        rst = 1'b1;

        step(); // edge 1
        chk_req("e1", 1'b1, 32'h0);
        chk("e1.valid", 64'(if_id_valid), 64'd0);
        step(); // edge 2
        chk_ifid("e2", 32'h4, 32'hA000_0000, 1'b1, 32'd1);
        chk_req("e2", 1'b1, 32'h4);
        step();
        chk_ifid("e3", 32'h8, 32'hA000_0004, 1'b1, 32'd2);
        chk_req("e3", 1'b1, 32'h8);

        // memory not ready for three cycles at pc=0x8
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.valid", 64'(if_id_valid), 64'd0);
            chk("stall.count", 64'(fetch_count), 64'd2);
            chk_req("stall", 1'b1, 32'h8);
        end
        imem_ready = 1'b1;
        step();
        chk_ifid("resume", 32'hC, 32'hA000_0008, 1'b1, 32'd3);
        step();
        chk_ifid("pre_frz", 32'h10, 32'hA000_000C, 1'b1, 32'd4);
        chk_req("pre_frz", 1'b1, 32'h10);

        // freeze two cycles while data at 0x10 returns
        freeze = 1'b1;
        step();
        chk_ifid("frz1", 32'h10, 32'hA000_000C, 1'b1, 32'd4);
        chk("frz1.req", 64'(imem_req), 64'd0);
        step();
        chk_ifid("frz2", 32'h10, 32'hA000_000C, 1'b1, 32'd4);
        chk("frz2.req", 64'(imem_req), 64'd0);
        freeze = 1'b0;
        step();
        chk_ifid("unfrz", 32'h14, 32'hA000_0010, 1'b1, 32'd5);
        chk_req("unfrz", 1'b1, 32'h14);
        step();
        chk_ifid("post_frz", 32'h18, 32'hA000_0014, 1'b1, 32'd6);

        // branch while fetching with ready=1
        branch_taken = 1'b1;
        branch_addr = 32'h40;
        step();
        chk_ifid("br", 32'h18, 32'h0, 1'b0, 32'd6);
        chk_req("br", 1'b0, 32'h40);
        branch_taken = 1'b0;
        step();
        chk_req("br_redir", 1'b1, 32'h40);
        chk("br_redir.valid", 64'(if_id_valid), 64'd0);
        step();
        chk_ifid("br_first", 32'h44, 32'hA000_0040, 1'b1, 32'd7);

        // branch and freeze together while in HOLD
        freeze = 1'b1;
        step();
        chk_ifid("hold_b", 32'h44, 32'hA000_0040, 1'b1, 32'd7);
        chk("hold_b.req", 64'(imem_req), 64'd0);
        branch_taken = 1'b1;
        branch_addr = 32'h80;
        step();
        chk_ifid("hold_br", 32'h44, 32'h0, 1'b0, 32'd7);
        chk_req("hold_br", 1'b0, 32'h80);
        branch_taken = 1'b0;
        freeze = 1'b0;
        step();
        chk_req("hold_redir", 1'b1, 32'h80);
        chk("hold_redir.valid", 64'(if_id_valid), 64'd0);
        step();
        chk_ifid("hold_first", 32'h84, 32'hA000_0080, 1'b1, 32'd8);

        // asynchronous reset in the middle of HOLD
        freeze = 1'b1;
        step();
        chk("rhold.req", 64'(imem_req), 64'd0);
        #2;
        rst = 1'b0;
        #1;
        chk_req("arst", 1'b0, 32'h0);
        chk_ifid("arst", 32'h0, 32'h0, 1'b0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        freeze = 1'b0;
        step();
        chk_req("rst_e1", 1'b1, 32'h0);
        chk("rst_e1.valid", 64'(if_id_valid), 64'd0);
        step();
        chk_ifid("rst_e2", 32'h4, 32'hA000_0000, 1'b1, 32'd1);

        // pc wraps past all-ones
        branch_taken = 1'b1;
        branch_addr = 32'hFFFF_FFFC;
        step();
        chk("wrap_br.count", 64'(fetch_count), 64'd1);
        branch_taken = 1'b0;
        step();
        chk_req("wrap_req", 1'b1, 32'hFFFF_FFFC);
        step();
        chk_ifid("wrap", 32'h0, 32'hFFFF_FFFC, 1'b1, 32'd2);
        chk_req("wrap", 1'b1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
